// File: rtl/i2c_slave.sv
// Oversampled I2C target: 2-FF synced SCL/SDA, START/STOP detect, 7-bit address match, byte RX/TX on open-drain SDA.
// Pin-to-detect 3 clk, SDA updates 4 clk after SCL pin falls; no backpressure (never stretches SCL).
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rw,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
    } state_t;

    state_t     state, state_n;
    logic       scl_s1, scl_s2, scl_q;
    logic       sda_s1, sda_s2, sda_q;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [3:0] cnt, cnt_n;
    logic [7:0] shift, shift_n;
    logic       sda_low, sda_low_n;
    logic       rw_n, busy_n, rx_valid_n, tx_req_n;
    logic [7:0] rx_data_n;

    assign sda = sda_low ? 1'b0 : 1'bz;

    // Sync chains idle high so leaving reset never fakes a START/STOP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_s1    <= 1'b1;
            scl_s2    <= 1'b1;
            scl_q     <= 1'b1;
            sda_s1    <= 1'b1;
            sda_s2    <= 1'b1;
            sda_q     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_s1    <= scl;
            scl_s2    <= scl_s1;
            scl_q     <= scl_s2;
            sda_s1    <= sda;
            sda_s2    <= sda_s1;
            sda_q     <= sda_s2;
            scl_rise  <= scl_s2 & ~scl_q;
            scl_fall  <= ~scl_s2 & scl_q;
            start_det <= scl_s2 & scl_q & sda_q & ~sda_s2;
            stop_det  <= scl_s2 & scl_q & ~sda_q & sda_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            shift    <= 8'd0;
            sda_low  <= 1'b0;
            rw       <= 1'b0;
            busy     <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            shift    <= shift_n;
            sda_low  <= sda_low_n;
            rw       <= rw_n;
            busy     <= busy_n;
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
            tx_req   <= tx_req_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shift_n    = shift;
        sda_low_n  = sda_low;
        rw_n       = rw;
        busy_n     = busy;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        tx_req_n   = 1'b0;

        if (start_det) begin
            state_n   = ADDR;
            cnt_n     = 4'd0;
            sda_low_n = 1'b0;
            busy_n    = 1'b0;
        end else if (stop_det) begin
            state_n   = IDLE;
            cnt_n     = 4'd0;
            sda_low_n = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_q};
                        cnt_n   = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        cnt_n = 4'd0;
                        if (shift[7:1] == SLAVE_ADDRESS) begin
                            sda_low_n = 1'b1;
                            rw_n      = shift[0];
                            busy_n    = 1'b1;
                            state_n   = ADDR_ACK;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw) begin
                            tx_req_n  = 1'b1;
                            shift_n   = {tx_data[6:0], 1'b0};
                            sda_low_n = ~tx_data[7];
                            cnt_n     = 4'd1;
                            state_n   = TX_DATA;
                        end else begin
                            sda_low_n = 1'b0;
                            cnt_n     = 4'd0;
                            state_n   = RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_q};
                        cnt_n   = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        rx_data_n  = shift;
                        rx_valid_n = 1'b1;
                        sda_low_n  = 1'b1;
                        cnt_n      = 4'd0;
                        state_n    = RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        sda_low_n = 1'b0;
                        state_n   = RX_DATA;
                    end
                end
                // cnt counts bits already placed on the bus; bit 7 goes out at load time.
                TX_DATA: begin
                    if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            sda_low_n = 1'b0;
                            cnt_n     = 4'd0;
                            state_n   = TX_ACK;
                        end else begin
                            sda_low_n = ~shift[7];
                            shift_n   = {shift[6:0], 1'b0};
                            cnt_n     = cnt + 4'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise && sda_q) begin
                        sda_low_n = 1'b0;
                        busy_n    = 1'b0;
                        state_n   = WAIT_STOP;
                    end else if (scl_fall) begin
                        tx_req_n  = 1'b1;
                        shift_n   = {tx_data[6:0], 1'b0};
                        sda_low_n = ~tx_data[7];
                        cnt_n     = 4'd1;
                        state_n   = TX_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Oversampled I2C target (slave) that answers the bus driven by the team's I2C master. It synchronizes SCL/SDA into the `clk` domain, detects START/STOP, matches a 7-bit address, ACKs, and then receives write bytes or transmits read bytes on the open-drain SDA line. It sits between the external I2C pins and a local byte-level register or FIFO interface.

## Interface
- `SLAVE_ADDRESS`, 7'h42: 7-bit address this target responds to.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `scl`  in  1  I2C clock from master (input only; no clock stretching).
- `sda`  inout  1  open-drain data. Only ever driven `0` or `z`.
- `tx_data`  in  8  read-byte source, sampled on the `tx_req` cycle.
- `tx_req`  out  1  one-cycle pulse: `tx_data` loaded into the shift register.
- `rx_data`  out  8  last received write byte; held until the next byte.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` updated.
- `rw`  out  1  R/W bit of the last matched address byte (1 = read).
- `busy`  out  1  high from address match until STOP, NACK-end, or repeated START.

## Operation
- Input path: 2-FF synchronizer on `scl` and `sda`, plus one previous-sample register each. Edges and conditions are decoded from the synchronized and previous samples:
  - `scl_rise` and `scl_fall` from the synchronized `scl`.
  - START: `sda` falls while `scl` is high.
  - STOP: `sda` rises while `scl` is high.
- Output path: register `sda_low`; `sda = sda_low ? 0 : z`.
- States: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
- START in any state: go to ADDR, clear the bit counter, set `sda_low` = 0. This covers repeated START.
- STOP in any state: go to IDLE, `sda_low` = 0, `busy` = 0. A partial byte is discarded with no `rx_valid`.
- ADDR: shift `sda` in MSB-first on each `scl_rise`. On the `scl_fall` after the 8th bit:
  - If byte[7:1] == `SLAVE_ADDRESS`: `sda_low` = 1, latch `rw` = byte[0], `busy` = 1, go to ADDR_ACK.
  - Otherwise go to WAIT_STOP; SDA stays released.
- ADDR_ACK: on `scl_fall`:
  - Write (`rw` = 0): release SDA, go to RX_DATA.
  - Read (`rw` = 1): pulse `tx_req`, load `tx_data`, drive bit 7 (`sda_low` = ~bit), go to TX_DATA.
- RX_DATA: shift on `scl_rise`. On the `scl_fall` after the 8th bit: `rx_data` = byte, pulse `rx_valid`, `sda_low` = 1, go to RX_ACK.
- RX_ACK: on `scl_fall`, release SDA and return to RX_DATA. Every byte is ACKed.
- TX_DATA: on each `scl_fall`, present the next bit. After the 8th bit's `scl_fall`, release SDA and go to TX_ACK.
- TX_ACK: sample `sda` on `scl_rise`.
  - ACK (0): on `scl_fall`, pulse `tx_req`, reload, drive bit 7, go to TX_DATA.
  - NACK (1): go to WAIT_STOP with SDA released; `busy` = 0.
- WAIT_STOP: ignore SCL edges; leave only on START or STOP.
- Bit counter: 4 bits, 0..8, cleared on START and at each byte/ACK boundary.

## Timing
- Reset values (cycle after `reset` = 0 sampled): `sda` = z, `rx_data` = 0, `rx_valid` = 0, `tx_req` = 0, `rw` = 0, `busy` = 0, state IDLE. Reset mid-ACK releases SDA on that cycle.
- Pin-to-detect latency: 3 `clk` (2 sync + edge register).
- SDA output changes 1 `clk` after detection, i.e. 4 `clk` after the `scl` pin falls.
- Requirement on the master: SCL low and high phases of at least 6 `clk` each. At the master's defaults (half bit = 3) the target will not keep up. Benches run with CLKS_PER_BIT ≥ 12.
- `rx_valid` and `tx_req` coincide with the `scl_fall` cycle that ends bit 8 and bit 9 respectively.
- `sda_low` never changes while synchronized `scl` is high, so the target never creates a false START or STOP.
- START and STOP take priority over any simultaneous data-state action in the same cycle.

## Test plan
- Write transaction: START, addr byte 0x84 (0x42, W), data 0xA5, 0x3C, STOP.
  - SDA low in both ACK slots and the address ACK slot.
  - `rx_valid` pulses twice with `rx_data` 0xA5 then 0x3C; `busy` = 0 after STOP.
- Address mismatch: START, byte 0x86 (0x43), data 0xFF, STOP.
  - SDA never driven, no `rx_valid`, `busy` stays 0.
- Read transaction: byte 0x85, `tx_data` 0xC3 then 0x5A; master ACKs the first byte and NACKs the second.
  - Bus carries 0xC3 then 0x5A; `tx_req` pulses twice.
  - SDA released after the NACK; state WAIT_STOP until STOP.
- Repeated START: write 0x84/0x11, then Sr, read 0x85.
  - `rx_valid` with 0x11, then `rw` = 1, then the read byte is driven.
- STOP after 4 bits of a write data byte: no `rx_valid`; `rx_data` keeps the prior value; state IDLE.
- Reset asserted while the target drives the ACK low: SDA = z the next cycle; all outputs at reset values.
